// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one UART transmit line between NUM_REQ byte sources. A round-robin
// arbiter picks one pending requester while the line is idle, and the chosen
// byte is then serialised as 8N1 (start, 8 data bits LSB first, stop).
//
// Ports
//   clk_in         system clock
//   rst_in         synchronous active-high reset, highest priority
//   req_valid_in   per-requester "byte pending"
//   req_data_in    byte of requester i at [8i+7:8i]
//   req_ready_out  one-hot, combinational; byte i accepted on valid & ready
//   tx_out         serial line, idle high (registered)
//   busy_out       high from the first start-bit cycle to the last stop-bit cycle
//   grant_id_out   index of the last accepted requester

module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [NUM_REQ-1:0]           req_valid_in,
    input  logic [8*NUM_REQ-1:0]         req_data_in,
    output logic [NUM_REQ-1:0]           req_ready_out,
    output logic                         tx_out,
    output logic                         busy_out,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id_out
);

    localparam int unsigned GID_W    = $clog2(NUM_REQ);
    localparam int unsigned LAST_BIT = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e             state_q;
    logic               tx_q;
    logic               busy_q;
    logic [GID_W-1:0]   grant_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;

    logic               wrap_c;
    logic               found_c;
    logic [GID_W-1:0]   sel_c;
    logic [GID_W-1:0]   idx_c;
    logic [7:0]         sel_byte_c;

    // Bit-period counter: >= so a corrupted out-of-range value still wraps.
    assign wrap_c = (cnt_q >= CNT_W'(CLKS_PER_BIT - 1));
    assign cnt_d  = wrap_c ? '0 : (cnt_q + CNT_W'(1));

    // Round-robin search starting one past the last grant.
    always_comb begin
        found_c = 1'b0;
        sel_c   = '0;
        idx_c   = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx_c = GID_W'((32'(grant_q) + 32'(1) + 32'(k)) % NUM_REQ);
            if (!found_c && req_valid_in[idx_c]) begin
                found_c = 1'b1;
                sel_c   = idx_c;
            end
        end
    end

    // Byte of the selected requester.
    always_comb begin
        sel_byte_c = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (sel_c == GID_W'(k)) begin
                sel_byte_c = req_data_in[8*k +: 8];
            end
        end
    end

    // Ready only in IDLE, and never while reset is being applied.
    always_comb begin
        req_ready_out = '0;
        if ((state_q == IDLE) && found_c && !rst_in) begin
            req_ready_out = NUM_REQ'(1) << sel_c;
        end
    end

    // Frame FSM with registered line and busy outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            grant_q   <= GID_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    if (found_c) begin
                        shift_q   <= sel_byte_c;
                        grant_q   <= sel_c;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end

                START: begin
                    cnt_q <= cnt_d;
                    if (wrap_c) begin
                        tx_q      <= shift_q[0];
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end
                end

                DATA: begin
                    cnt_q <= cnt_d;
                    if (wrap_c) begin
                        if (bit_idx_q == 3'(LAST_BIT)) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            // Next bit sits at [1] before the shift takes effect.
                            tx_q      <= shift_q[1];
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'(1);
                        end
                    end
                end

                STOP: begin
                    cnt_q <= cnt_d;
                    if (wrap_c) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_out       = tx_q;
    assign busy_out     = busy_q;
    assign grant_id_out = grant_q;

endmodule
